// File: rtl/iaq_pkg.sv
// Shared constants for the G.726 inverse adaptive quantizer: rate codes, widths
// and the RECONST log-magnitude tables indexed by the decoded magnitude.
package iaq_pkg;

  localparam logic [1:0] RATE_40K = 2'b00;
  localparam logic [1:0] RATE_32K = 2'b01;
  localparam logic [1:0] RATE_24K = 2'b10;
  localparam logic [1:0] RATE_16K = 2'b11;

  localparam int Y_W  = 13;
  localparam int DQ_W = 15;

  // Log of zero: drives DQL negative for any legal Y, which forces DQMAG to 0.
  localparam logic signed [11:0] DQLN_MIN = 12'sh800;

  localparam logic signed [11:0] DQLN_40K [16] = '{
    DQLN_MIN, -12'sd66, 12'sd28,  12'sd104, 12'sd169, 12'sd224, 12'sd274, 12'sd318,
    12'sd358, 12'sd395, 12'sd429, 12'sd459, 12'sd488, 12'sd514, 12'sd539, 12'sd566
  };

  localparam logic signed [11:0] DQLN_32K [8] = '{
    DQLN_MIN, 12'sd4, 12'sd135, 12'sd213, 12'sd273, 12'sd323, 12'sd373, 12'sd425
  };

  localparam logic signed [11:0] DQLN_24K [4] = '{
    DQLN_MIN, 12'sd135, 12'sd273, 12'sd373
  };

  localparam logic signed [11:0] DQLN_16K [2] = '{
    12'sd116, 12'sd365
  };

endpackage

// File: rtl/reconst_lut.sv
// RECONST lookup: (rate, magnitude index) -> DQLN, purely combinational.
module reconst_lut
  import iaq_pkg::*;
(
  input  logic [1:0]  rate_i,
  input  logic [3:0]  mag_i,
  output logic [11:0] dqln_o
);

  always_comb begin
    dqln_o = DQLN_MIN;
    case (rate_i)
      RATE_40K: dqln_o = DQLN_40K[mag_i];
      RATE_32K: dqln_o = DQLN_32K[mag_i[2:0]];
      RATE_24K: dqln_o = DQLN_24K[mag_i[1:0]];
      default:  dqln_o = DQLN_16K[mag_i[0]];
    endcase
  end

endmodule

// File: rtl/inv_adap_quan_pipe.sv
// G.726 inverse adaptive quantizer (RECONST / ADDA / ANTILOG), 3 enabled cycles, hold freezes all stages.
// Optional IAQ_SAMPLE_COUNT_EN adds a saturating count of emitted samples on sample_cnt.
module inv_adap_quan_pipe #(
  parameter int PIPE_STAGES = 3,
  parameter int Y_W         = iaq_pkg::Y_W,
  parameter int DQ_W        = iaq_pkg::DQ_W
) (
  input  logic            CLK,
  input  logic            reset,
  input  logic            hold,
  input  logic            in_valid,
  input  logic [4:0]      IC,
  input  logic [1:0]      RATE,
  input  logic [Y_W-1:0]  Y,
  output logic            out_valid,
  output logic [DQ_W-1:0] DQ,
  output logic [11:0]     DQLN_o
`ifdef IAQ_SAMPLE_COUNT_EN
  ,
  output logic [15:0]     sample_cnt
`endif
);

  import iaq_pkg::*;

  if (PIPE_STAGES != 3) begin : g_bad_depth
    $error("inv_adap_quan_pipe: PIPE_STAGES must be 3");
  end

  logic            v1_q, v2_q, v3_q;
  logic            dqs1_q, dqs2_q;
  logic [11:0]     dqln_q;
  logic [Y_W-1:0]  y_q;
  logic [11:0]     dql_q;
  logic [DQ_W-1:0] dq_q;

  // ---------------- Stage 1: codeword decode + RECONST ----------------
  logic        dqs_d;
  logic [3:0]  mag_d;
  logic [11:0] dqln_d;

  always_comb begin
    dqs_d = 1'b0;
    mag_d = 4'd0;
    case (RATE)
      RATE_40K: begin
        dqs_d = IC[4];
        mag_d = IC[4] ? ~IC[3:0] : IC[3:0];
      end
      RATE_32K: begin
        dqs_d = IC[3];
        mag_d = {1'b0, (IC[3] ? ~IC[2:0] : IC[2:0])};
      end
      RATE_24K: begin
        dqs_d = IC[2];
        mag_d = {2'b00, (IC[2] ? ~IC[1:0] : IC[1:0])};
      end
      default: begin
        // 2-bit codes fold sign into the single magnitude bit.
        dqs_d = IC[1];
        mag_d = {3'b000, IC[0] ^ IC[1]};
      end
    endcase
  end

  reconst_lut u_reconst_lut (
    .rate_i (RATE),
    .mag_i  (mag_d),
    .dqln_o (dqln_d)
  );

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      v1_q   <= 1'b0;
      dqs1_q <= 1'b0;
      dqln_q <= 12'd0;
      y_q    <= '0;
    end else if (!hold) begin
      v1_q <= in_valid;
      if (in_valid) begin
        dqs1_q <= dqs_d;
        dqln_q <= dqln_d;
        y_q    <= Y;
      end
    end
  end

  // ---------------- Stage 2: ADDA, log-domain scaling ----------------
  logic [11:0] dql_d;
  logic        unused_y;

  assign dql_d    = dqln_q + {1'b0, y_q[Y_W-1:2]};
  assign unused_y = ^y_q[1:0];

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      v2_q   <= 1'b0;
      dqs2_q <= 1'b0;
      dql_q  <= 12'd0;
    end else if (!hold) begin
      v2_q <= v1_q;
      if (v1_q) begin
        dqs2_q <= dqs1_q;
        dql_q  <= dql_d;
      end
    end
  end

  // ---------------- Stage 3: ANTILOG ----------------
  logic [3:0]  dex;
  logic [7:0]  dqt;
  logic [29:0] ant_sh;
  logic [13:0] dqmag_d;
  logic        unused_ant;

  assign dex = dql_q[10:7];
  assign dqt = {1'b1, dql_q[6:0]};
  // Shift left by DEX then take bits [27:14]: same as (DQT<<7)>>(14-DEX) without a negative shift.
  assign ant_sh     = {15'd0, dqt, 7'd0} << dex;
  assign dqmag_d    = dql_q[11] ? 14'd0 : ant_sh[27:14];
  assign unused_ant = ^{ant_sh[29:28], ant_sh[13:0]};

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      v3_q <= 1'b0;
      dq_q <= '0;
    end else if (!hold) begin
      v3_q <= v2_q;
      if (v2_q) begin
        dq_q <= {dqs2_q, dqmag_d};
      end
    end
  end

  assign out_valid = v3_q;
  assign DQ        = dq_q;
  assign DQLN_o    = dqln_q;

`ifdef IAQ_SAMPLE_COUNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      cnt_q <= 16'd0;
    end else if (v3_q && !hold && (cnt_q != 16'hFFFF)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign sample_cnt = cnt_q;
`else
`endif

endmodule
